// File: rtl/arm_register_file_pkg.sv
// Shared CPU constants for the register bank: widths, PC index and named registers.
package arm_register_file_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

  // Architecturally named register indices.
  typedef enum logic [REG_ADDR_W-1:0] {
    REG_SP = 4'd13,
    REG_LR = 4'd14,
    REG_PC = 4'd15
  } reg_idx_e;

endpackage

// File: rtl/arm_register_file_if.sv
// Decode/ALU-side bus of the register bank: two read ports, one write port, PC feed.
interface arm_register_file_if
  import arm_register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W
);

  logic [ADDR_WIDTH-1:0] add_portA_in;
  logic [ADDR_WIDTH-1:0] add_portB_in;
  logic [ADDR_WIDTH-1:0] add_write_in;
  logic [DATA_WIDTH-1:0] pc_R15;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write_en_in;
  logic [DATA_WIDTH-1:0] data_portA_out;
  logic [DATA_WIDTH-1:0] data_portB_out;

  // Driver side: decode/fetch/write-back logic.
  modport master (
    output add_portA_in, add_portB_in, add_write_in, pc_R15, data_in, write_en_in,
    input  data_portA_out, data_portB_out
  );

  // Register bank side.
  modport slave (
    input  add_portA_in, add_portB_in, add_write_in, pc_R15, data_in, write_en_in,
    output data_portA_out, data_portB_out
  );

endinterface

// File: rtl/arm_register_file_rf_read_port.sv
// Combinational read port: returns pc_i for the PC address, otherwise the stored register.
module rf_read_port
  import arm_register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned PC_INDEX   = 15,
  parameter int unsigned NUM_STORE  = (2 ** ADDR_WIDTH) - 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_STORE],
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Select PC or the addressed storage entry; compare-based so no index can run off the array.
  always_comb begin
    data_o = '0;
    if (addr_i == ADDR_WIDTH'(PC_INDEX)) begin
      data_o = pc_i;
    end else begin
      for (int unsigned i = 0; i < NUM_STORE; i++) begin
        if (addr_i == ADDR_WIDTH'(i)) begin
          data_o = regs_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/arm_register_file.sv
// ARM-style register bank: R0-R14 stored, R15 mapped to the externally supplied PC.
module arm_register_file
  import arm_register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned PC_INDEX   = 15
) (
  input  logic clk_in,
  input  logic rst_in,
  arm_register_file_if.slave rf
);

  // PC is the highest index, so storage covers every index below it.
  localparam int unsigned NUM_STORE = (2 ** ADDR_WIDTH) - 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_STORE];
  logic [DATA_WIDTH-1:0] regs_d [NUM_STORE];

  // Next-state: load the addressed register on an enabled write; PC-address writes match nothing.
  always_comb begin
    for (int unsigned i = 0; i < NUM_STORE; i++) begin
      regs_d[i] = regs_q[i];
      if (rf.write_en_in && (rf.add_write_in == ADDR_WIDTH'(i)) &&
          (rf.add_write_in != ADDR_WIDTH'(PC_INDEX))) begin
        regs_d[i] = rf.data_in;
      end
    end
  end

  // Storage update; synchronous reset clears every register and overrides any write.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NUM_STORE; i++) begin
      if (rst_in) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_INDEX   (PC_INDEX),
    .NUM_STORE  (NUM_STORE)
  ) u_port_a (
    .addr_i (rf.add_portA_in),
    .regs_i (regs_q),
    .pc_i   (rf.pc_R15),
    .data_o (rf.data_portA_out)
  );

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_INDEX   (PC_INDEX),
    .NUM_STORE  (NUM_STORE)
  ) u_port_b (
    .addr_i (rf.add_portB_in),
    .regs_i (regs_q),
    .pc_i   (rf.pc_R15),
    .data_o (rf.data_portB_out)
  );

endmodule

// File: tb/tb_arm_register_file.sv
// Directed, table-driven bench for arm_register_file.
module tb_arm_register_file;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  int tests  = 0;
  int failed = 0;

  arm_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) rf_if ();

  arm_register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .PC_INDEX   (15)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rf     (rf_if.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] pc;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] exp_regs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock edge with the given reset/write controls, then controls return idle.
  task automatic cycle(input logic rst, input logic we, input logic [3:0] wa, input logic [31:0] wd);
    rst_in = rst;
    rf_if.write_en_in  = we;
    rf_if.add_write_in = wa;
    rf_if.data_in      = wd;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    rf_if.write_en_in = 1'b0;
  endtask

  initial begin
    rf_if.add_portA_in = '0;
    rf_if.add_portB_in = '0;
    rf_if.add_write_in = '0;
    rf_if.pc_R15       = '0;
    rf_if.data_in      = '0;
    rf_if.write_en_in  = 1'b0;

    //                rst  we   wa     wd             ra     rb     pc             expA           expB
    vecs[0] = '{1'b1, 1'b0, 4'd0,  32'h0,         4'd0,  4'd14, 32'h0,         32'h0,         32'h0};
    vecs[1] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd3,  4'd4,  32'h0,         32'h0,         32'h0};
    vecs[2] = '{1'b0, 1'b1, 4'd3,  32'hDEADBEEF,  4'd3,  4'd3,  32'h0,         32'hDEADBEEF,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd2,  4'd4,  32'h0,         32'h0,         32'h0};
    vecs[4] = '{1'b0, 1'b1, 4'd15, 32'h12345678,  4'd15, 4'd3,  32'h0000010C,  32'h0000010C,  32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 4'd5,  32'hFFFFFFFF,  4'd5,  4'd15, 32'h0,         32'h0,         32'h0};
    vecs[6] = '{1'b0, 1'b1, 4'd5,  32'hFFFFFFFF,  4'd5,  4'd3,  32'h0,         32'hFFFFFFFF,  32'hDEADBEEF};
    vecs[7] = '{1'b0, 1'b1, 4'd0,  32'h00000001,  4'd0,  4'd13, 32'h0,         32'h00000001,  32'h0};
    vecs[8] = '{1'b0, 1'b1, 4'd14, 32'h00000E0E,  4'd14, 4'd0,  32'h0,         32'h00000E0E,  32'h00000001};
    vecs[9] = '{1'b0, 1'b1, 4'd13, 32'h0000000D,  4'd13, 4'd14, 32'h0,         32'h0000000D,  32'h00000E0E};

    // Register contents expected once the table has been applied.
    foreach (exp_regs[i]) exp_regs[i] = 32'h0;
    exp_regs[0]  = 32'h00000001;
    exp_regs[3]  = 32'hDEADBEEF;
    exp_regs[5]  = 32'hFFFFFFFF;
    exp_regs[13] = 32'h0000000D;
    exp_regs[14] = 32'h00000E0E;

    // Initial reset and full sweep: A ascending, B descending.
    cycle(1'b1, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      rf_if.add_portA_in = 4'(i);
      rf_if.add_portB_in = 4'(14 - i);
      #1;
      check($sformatf("reset_A_R%0d", i), rf_if.data_portA_out, 32'h0);
      check($sformatf("reset_B_R%0d", 14 - i), rf_if.data_portB_out, 32'h0);
    end

    // Table vectors.
    for (int v = 0; v < 10; v++) begin
      cycle(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd);
      rf_if.add_portA_in = vecs[v].ra;
      rf_if.add_portB_in = vecs[v].rb;
      rf_if.pc_R15       = vecs[v].pc;
      #1;
      check($sformatf("vec%0d_A", v), rf_if.data_portA_out, vecs[v].ea);
      check($sformatf("vec%0d_B", v), rf_if.data_portB_out, vecs[v].eb);
    end

    // PC mapping follows pc_R15 without a clock edge; writes to 15 are dropped.
    rf_if.add_portA_in = 4'd15;
    rf_if.pc_R15 = 32'h00000108;
    #1;
    check("pc_108", rf_if.data_portA_out, 32'h00000108);
    rf_if.pc_R15 = 32'h0000010C;
    #1;
    check("pc_follow_10C", rf_if.data_portA_out, 32'h0000010C);
    cycle(1'b0, 1'b1, 4'd15, 32'h12345678);
    check("pc_after_wr15", rf_if.data_portA_out, 32'h0000010C);
    for (int i = 0; i < 15; i++) begin
      rf_if.add_portB_in = 4'(i);
      #1;
      check($sformatf("wr15_unchanged_R%0d", i), rf_if.data_portB_out, exp_regs[i]);
    end

    // Read-during-write: old value until the edge, new value right after.
    cycle(1'b0, 1'b1, 4'd7, 32'h11111111);
    rf_if.add_portA_in = 4'd7;
    #1;
    check("rdw_initial", rf_if.data_portA_out, 32'h11111111);
    rf_if.data_in      = 32'h22222222;
    rf_if.add_write_in = 4'd7;
    rf_if.write_en_in  = 1'b1;
    #1;
    check("rdw_before_edge", rf_if.data_portA_out, 32'h11111111);
    @(posedge clk_in);
    #1;
    rf_if.write_en_in = 1'b0;
    check("rdw_after_edge", rf_if.data_portA_out, 32'h22222222);

    // Reset wins over a simultaneous write and clears earlier contents.
    cycle(1'b1, 1'b1, 4'd1, 32'hAAAAAAAA);
    rf_if.add_portA_in = 4'd1;
    rf_if.add_portB_in = 4'd3;
    #1;
    check("rstprio_R1", rf_if.data_portA_out, 32'h0);
    check("rstprio_R3", rf_if.data_portB_out, 32'h0);
    rf_if.add_portA_in = 4'd7;
    rf_if.add_portB_in = 4'd7;
    #1;
    check("rstprio_R7_A", rf_if.data_portA_out, 32'h0);
    check("rstprio_R7_B", rf_if.data_portB_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/arm_register_file.md
Name: arm_register_file

Overview:
- ARM-style general-purpose register bank for the CPU datapath: R0–R14 are storage registers; R15 is the program counter, which is owned by the fetch stage.
- Two combinational read ports (A, B) and one synchronous write port.
- Reads of address 15 return the externally supplied pc_R15 value; the caller supplies any PC+8 adjustment.
- Sits between instruction decode (register addresses) and the ALU/memory stage (operands, write-back data).

Parameters:
- DATA_WIDTH, 32, register and data bus width in bits.
- ADDR_WIDTH, 4, register address width; register count = 2**ADDR_WIDTH = 16.
- PC_INDEX, 15, index of the register mapped to pc_R15.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- add_portA_in  input  ADDR_WIDTH  read address, port A.
- add_portB_in  input  ADDR_WIDTH  read address, port B.
- add_write_in  input  ADDR_WIDTH  write address.
- pc_R15  input  DATA_WIDTH  current PC value, returned on reads of R15.
- data_in  input  DATA_WIDTH  write data.
- write_en_in  input  1  write enable.
- data_portA_out  output  DATA_WIDTH  read data, port A.
- data_portB_out  output  DATA_WIDTH  read data, port B.

Behaviour:
- Storage: 15 registers, R0–R14, each DATA_WIDTH bits. R15 has no storage.
- Reset: on a rising clk_in with rst_in=1, R0–R14 are set to 0.
  - Reset has priority over write_en_in; no write occurs that cycle.
  - After reset, a read of any address 0–14 returns 0.
- Write: on a rising clk_in with rst_in=0, write_en_in=1 and add_write_in != 15, register[add_write_in] is loaded with data_in.
  - A write with add_write_in=15 is silently ignored; no register changes.
  - write_en_in=0 means no state change.
- Reads: purely combinational, zero latency.
  - data_portX_out = pc_R15 when the port address is 15, otherwise register[addr].
  - The output follows pc_R15 combinationally while the address is 15.
- Read-during-write to the same address: no bypass. The port returns the old value until the rising edge, then the new value immediately after.
- Both ports may address the same register simultaneously; both return identical data.
- Reset mid-stream: register contents before reset are discarded. Outputs for addresses 0–14 are 0 from the edge where reset is sampled until the next write.
- Outputs have no reset value of their own; they are combinational functions of the stored state, pc_R15 and the addresses.
- No X propagation: all 15 registers are reset, so every address is defined after the first reset.
- Width rules: no arithmetic inside the block; data is passed unmodified at DATA_WIDTH bits.

Decomposition:
- Shared CPU package holds:
  - constants REG_ADDR_W=4, DATA_W=32, PC_REG=4'd15;
  - named register indices (SP=13, LR=14, PC=15).
- One natural sub-module: rf_read_port. It is a combinational mux selecting register[addr] or pc_R15, and is instantiated twice for ports A and B.
- Storage array and write logic stay in the top module.

Test Plan:
- Reset: hold rst_in=1 for 1 cycle, release. Read A=0..14, B=14..0 → all outputs 0x00000000.
- Write/read: write 0xDEADBEEF to R3 (we=1, add_write_in=3), then A=3, B=3 → both 0xDEADBEEF. R2 and R4 remain 0.
- PC mapping: pc_R15=0x00000108, A=15 → 0x00000108. Change pc_R15 to 0x0000010C with no clock edge → A follows to 0x0000010C. Then write 0x12345678 to address 15 and read again with pc_R15 still 0x0000010C → A still 0x0000010C, and R0–R14 unchanged.
- Write enable gating: we=0, add_write_in=5, data_in=0xFFFFFFFF, clock → R5 still 0. With we=1 → R5=0xFFFFFFFF.
- Read-during-write: R7=0x11111111, A=7. Present data_in=0x22222222, we=1 → A=0x11111111 before the edge, 0x22222222 after.
- Reset priority: rst_in=1 and we=1 writing 0xAAAAAAAA to R1 in the same cycle → R1=0. Also confirm a prior R3 value is cleared to 0.
